conv_ctrl: RTL

CONV_CTRL -- requirements
Module: conv_ctrl

---
 rtl/conv_pkg.sv | 29 ++
 rtl/conv_addr_gen.sv | 80 ++++++++
 rtl/conv_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the 4x4 convolution controller.
package conv_pkg;

  localparam int unsigned KSIZE    = 4;
  localparam int unsigned NUM_TAPS = KSIZE * KSIZE;
  localparam int unsigned TAP_W    = 4;
  localparam int unsigned DATA_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_FETCH   = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_WRITE   = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  // Per-cycle commands from the FSM to the address generator.
  typedef struct packed {
    logic load_base;
    logic fetch;
    logic advance;
  } agen_ctrl_t;

  typedef logic [TAP_W-1:0]  tap_t;
  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/conv_addr_gen.sv
// Tap and output-position counters plus incremental input/output address generation.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W = 6,
  parameter int unsigned IMG_H = 6,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  agen_ctrl_t    ctrl,
  output logic          last_tap,
  output logic          last_out,
  output logic [AW-1:0] in_addr,
  output logic [AW-1:0] w_addr,
  output logic [AW-1:0] out_addr
);

  localparam int unsigned OUT_W = IMG_W - KSIZE + 1;
  localparam int unsigned OUT_H = IMG_H - KSIZE + 1;
  // Jump from the last column of a kernel row to the first column of the next.
  localparam logic [AW-1:0] ROW_STEP  = AW'(IMG_W - KSIZE + 1);
  // Window base moves from the last output column to the next image row.
  localparam logic [AW-1:0] WRAP_STEP = AW'(KSIZE);

  tap_t          tap;
  logic [AW-1:0] orow;
  logic [AW-1:0] ocol;
  logic [AW-1:0] base;
  logic          last_col;

  assign last_col = (ocol == AW'(OUT_W - 1));
  assign last_out = last_col && (orow == AW'(OUT_H - 1));
  assign last_tap = (tap == TAP_W'(NUM_TAPS - 1));
  assign w_addr   = AW'(tap);

  // Tap counter and input read address walk the 4x4 window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap     <= '0;
      in_addr <= '0;
    end else begin
      if (ctrl.fetch) begin
        tap <= tap + TAP_W'(1);
      end
      if (ctrl.load_base) begin
        in_addr <= base;
      end else if (ctrl.fetch) begin
        in_addr <= in_addr + ((tap[1:0] == 2'(KSIZE - 1)) ? ROW_STEP : AW'(1));
      end
    end
  end

  // Output position, window base and output address advance once per output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      orow     <= '0;
      ocol     <= '0;
      base     <= '0;
      out_addr <= '0;
    end else if (ctrl.advance) begin
      if (last_out) begin
        orow     <= '0;
        ocol     <= '0;
        base     <= '0;
        out_addr <= '0;
      end else if (last_col) begin
        ocol     <= '0;
        orow     <= orow + AW'(1);
        base     <= base + WRAP_STEP;
        out_addr <= out_addr + AW'(1);
      end else begin
        ocol     <= ocol + AW'(1);
        base     <= base + AW'(1);
        out_addr <= out_addr + AW'(1);
      end
    end
  end

endmodule

// File: rtl/conv_ctrl.sv
// Frame-level FSM for a 4x4 stride-1 valid convolution; outputs are registered
// from the next state so they line up with the state they describe.
module conv_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W = 6,
  parameter int unsigned IMG_H = 6,
  parameter int unsigned AW    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [AW-1:0]     in_addr,
  output logic [AW-1:0]     w_addr,
  output logic              mac_clr,
  output logic              mac_en,
  input  logic [DATA_W-1:0] mac_result,
  output logic              out_we,
  output logic [AW-1:0]     out_addr,
  output logic [DATA_W-1:0] out_data
);

  state_t     st;
  state_t     nst;
  agen_ctrl_t agen_ctrl;
  logic       last_tap;
  logic       last_out;

  conv_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .AW    (AW)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .ctrl     (agen_ctrl),
    .last_tap (last_tap),
    .last_out (last_out),
    .in_addr  (in_addr),
    .w_addr   (w_addr),
    .out_addr (out_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= ST_IDLE;
    end else begin
      st <= nst;
    end
  end

  always_comb begin
    nst       = st;
    agen_ctrl = '0;
    case (st)
      ST_IDLE: begin
        if (start) nst = ST_CLEAR;
      end
      ST_CLEAR: begin
        agen_ctrl.load_base = 1'b1;
        nst                 = ST_FETCH;
      end
      ST_FETCH: begin
        agen_ctrl.fetch = 1'b1;
        if (last_tap) nst = ST_DRAIN;
      end
      ST_DRAIN:   nst = ST_CAPTURE;
      ST_CAPTURE: nst = ST_WRITE;
      ST_WRITE: begin
        agen_ctrl.advance = 1'b1;
        nst               = last_out ? ST_DONE : ST_CLEAR;
      end
      ST_DONE:    nst = ST_IDLE;
      default:    nst = ST_IDLE;
    endcase
  end

  // mac_en trails mem_rd by one cycle to match the memories' read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_rd   <= 1'b0;
      mac_clr  <= 1'b0;
      mac_en   <= 1'b0;
      out_we   <= 1'b0;
      out_data <= '0;
    end else begin
      busy    <= (nst != ST_IDLE);
      done    <= (nst == ST_DONE);
      mem_rd  <= (nst == ST_FETCH);
      mac_clr <= (nst == ST_CLEAR);
      mac_en  <= mem_rd;
      out_we  <= (nst == ST_WRITE);
      if (st == ST_CAPTURE) begin
        out_data <= mac_result;
      end
    end
  end

endmodule
